// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and fetch sequencer feeding instruction memory and decode
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter logic [31:0] MAX_ADDR = 32'h0000_007C,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d, next_pc;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             fault_q, fault_d, pc_valid_q, halted_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = jump ? jump_target : branch_taken ? branch_target : pc_plus4;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (pc_q > MAX_ADDR) begin
                state_d = HALT;
                fault_d = 1'b1;
            end else if (instruction == 32'h0) begin
                state_d = HALT;
            end else if (!stall) begin
                if (next_pc[1:0] != 2'b00) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    pc_d      = next_pc;
                    retired_d = &retired_q ? retired_q : retired_q + CNT_W'(1);
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            retired_q  <= '0;
            fault_q    <= 1'b0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            fault_q    <= fault_d;
            pc_valid_q <= state_d == RUN;
            halted_q   <= state_d == HALT;
        end
    end
    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign halted   = halted_q;
    assign fault    = fault_q;
    assign retired  = retired_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors with hand-computed expectations for pc_fetch_unit
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] instruction, branch_target, jump_target;
    logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
    logic        pc_valid, halted, fault, pc_valid2, halted2, fault2;
    logic [15:0] retired;
    logic [1:0]  retired2;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .pc(pc), .pc_plus4(pc_plus4),
        .pc_valid(pc_valid), .halted(halted), .fault(fault), .retired(retired)
    );

    pc_fetch_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .pc(pc2), .pc_plus4(pc_plus4_2),
        .pc_valid(pc_valid2), .halted(halted2), .fault(fault2), .retired(retired2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic state(input string tag, input logic [31:0] epc, input logic ev,
                         input logic eh, input logic ef, input logic [31:0] er);
        check({tag, ".pc"}, pc, epc);
        check({tag, ".valid"}, 32'(pc_valid), 32'(ev));
        check({tag, ".halted"}, 32'(halted), 32'(eh));
        check({tag, ".fault"}, 32'(fault), 32'(ef));
        check({tag, ".retired"}, 32'(retired), er);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        instruction = 32'hxxxx_xxxx; branch_target = '0; jump_target = '0;
        step(2);
        state("rst", 32'h4, 0, 0, 0, 0);
        reset = 1'b1;
        step(1);
        instruction = 32'h00A0_0213;
        state("idle_exit", 32'h4, 1, 0, 0, 0);
        step(1);
        state("seq1", 32'h8, 1, 0, 0, 1);
        step(1);
        state("seq2", 32'hC, 1, 0, 0, 2);
        check("seq2.retired2", 32'(retired2), 2);
        step(3);
        state("seq5", 32'h18, 1, 0, 0, 5);
        check("sat.retired2", 32'(retired2), 3);
        check("pc_plus4", pc_plus4, 32'h1C);
        branch_taken = 1'b1; branch_target = 32'h40;
        step(1);
        state("branch", 32'h40, 1, 0, 0, 6);
        jump = 1'b1; jump_target = 32'h14;
        step(1);
        state("jump_wins", 32'h14, 1, 0, 0, 7);
        branch_taken = 1'b0; jump_target = 32'h20;
        step(1);
        check("to20.pc", pc, 32'h20);
        stall = 1'b1; jump_target = 32'h60;
        for (int i = 0; i < 3; i++) begin
            step(1);
            state("stall", 32'h20, 1, 0, 0, 8);
        end
        stall = 1'b0;
        step(1);
        state("unstall", 32'h60, 1, 0, 0, 9);
        jump = 1'b0;
        step(2);
        state("to68", 32'h68, 1, 0, 0, 11);
        instruction = 32'h0;
        step(1);
        state("eop", 32'h68, 0, 1, 0, 11);
        instruction = 32'h00A0_0213; jump = 1'b1; jump_target = 32'h10;
        step(2);
        state("eop_frozen", 32'h68, 0, 1, 0, 11);
        jump_target = 32'h22;
        do_reset();
        state("rst2", 32'h4, 0, 0, 0, 0);
        step(2);
        state("misalign", 32'h4, 0, 1, 1, 0);
        jump_target = 32'h80;
        do_reset();
        step(2);
        state("to80", 32'h80, 1, 0, 0, 1);
        step(1);
        state("over_max", 32'h80, 0, 1, 1, 1);
        jump_target = 32'hFFFF_FFFC;
        do_reset();
        step(2);
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.pc_plus4", pc_plus4, 32'h0);
        jump_target = 32'h3C;
        do_reset();
        step(2);
        jump = 1'b0; stall = 1'b1;
        step(1);
        state("at3c", 32'h3C, 1, 0, 0, 1);
        reset = 1'b0;
        step(1);
        state("mid_rst", 32'h4, 0, 0, 0, 0);
        check("mid_rst.retired2", 32'(retired2), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
